// File: rtl/interrupt_controller_pkg.sv
// Shared constants and helpers for the multi-channel interrupt controller.
// Holds vector defaults, trigger-mode encodings and the index-width function.
package interrupt_controller_pkg;

  localparam logic [15:0] VecBaseDefault   = 16'h0004;
  localparam int unsigned VecStrideDefault = 4;

  localparam logic ModeLevel = 1'b0;
  localparam logic ModeEdge  = 1'b1;

  // Width needed to encode n distinct values, never less than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_priority_encoder.sv
// Combinational fixed-priority encoder: reports the lowest set request index.
module int_priority_encoder #(
  parameter int unsigned Width = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic [Width-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest index is the last (winning) assignment.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Multi-channel interrupt controller with per-channel edge/level mode, masking,
// fixed priority and nested pre-emption, evaluated at instruction commit.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int unsigned NUM_INT    = 4,
  parameter int unsigned NEST_DEPTH = 2,
  parameter logic [15:0] VEC_BASE   = VecBaseDefault,
  parameter int unsigned VEC_STRIDE = VecStrideDefault,
  localparam int unsigned IdW       = clog2w(NUM_INT),
  localparam int unsigned LvlW      = clog2w(NEST_DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               COMMIT,
  input  logic               EIX,
  input  logic               DIX,
  input  logic               RETIX,
  input  logic [NUM_INT-1:0] INT_IN,
  input  logic [NUM_INT-1:0] EDGE_MODE,
  input  logic [NUM_INT-1:0] INT_MASK,
  output logic               PC_LD_INT,
  output logic [15:0]        INT_VECTOR,
  output logic [IdW-1:0]     INT_ID,
  output logic               IEN,
  output logic [NUM_INT-1:0] PENDING,
  output logic [NUM_INT-1:0] IN_SERVICE,
  output logic [LvlW-1:0]    NEST_LEVEL
);

  logic [NUM_INT-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_INT-1:0] pending_q, pending_d;
  logic [NUM_INT-1:0] in_service_q, in_service_d;
  logic               ien_q, ien_d;
  logic [LvlW-1:0]    nest_q, nest_d;
  logic [IdW-1:0]     stack_q [NEST_DEPTH];
  logic [IdW-1:0]     stack_d [NEST_DEPTH];

  logic [NUM_INT-1:0] edge_det, pend_vis, cand;
  logic [IdW-1:0]     sel, top_id;
  logic               sel_valid, take, do_pop;

  assign edge_det = sync2_q & ~prev_q;

  // Level channels expose the synchronised line directly; edge channels the latch.
  always_comb begin
    pend_vis = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      pend_vis[i] = (EDGE_MODE[i] == ModeLevel) ? sync2_q[i] : pending_q[i];
    end
  end

  assign cand = pend_vis & INT_MASK;

  int_priority_encoder #(
    .Width(NUM_INT),
    .IdxW (IdW)
  ) u_prio (
    .req_i  (cand),
    .idx_o  (sel),
    .valid_o(sel_valid)
  );

  always_comb begin
    top_id = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (LvlW'(i + 1) == nest_q) top_id = stack_q[i];
    end
  end

  assign take = COMMIT && ien_q && sel_valid && !DIX && !RETIX &&
                (nest_q < LvlW'(NEST_DEPTH)) && ((nest_q == '0) || (sel < top_id));
  assign do_pop = COMMIT && RETIX && (nest_q != '0);

  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    stack_d      = stack_q;
    nest_d       = nest_q;
    ien_d        = ien_q;

    // A fresh edge beats the take-clear on the same channel.
    for (int i = 0; i < NUM_INT; i++) begin
      if (take && (sel == IdW'(i))) pending_d[i] = 1'b0;
      if (edge_det[i])               pending_d[i] = 1'b1;
      if (EDGE_MODE[i] != ModeEdge)  pending_d[i] = 1'b0;
    end

    if (take) begin
      in_service_d[sel] = 1'b1;
      for (int j = 0; j < NEST_DEPTH; j++) begin
        if (LvlW'(j) == nest_q) stack_d[j] = sel;
      end
      nest_d = nest_q + LvlW'(1);
    end

    if (do_pop) begin
      in_service_d[top_id] = 1'b0;
      nest_d               = nest_q - LvlW'(1);
    end

    if (COMMIT) begin
      if (EIX || RETIX) ien_d = 1'b1;
      if (DIX || take)  ien_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      ien_q        <= 1'b0;
      nest_q       <= '0;
      stack_q      <= '{default: '0};
    end else begin
      sync1_q      <= INT_IN;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      ien_q        <= ien_d;
      nest_q       <= nest_d;
      stack_q      <= stack_d;
    end
  end

  assign PC_LD_INT  = take;
  assign INT_ID     = sel;
  assign INT_VECTOR = VEC_BASE + (16'(sel) * 16'(VEC_STRIDE));
  assign IEN        = ien_q;
  assign PENDING    = pend_vis;
  assign IN_SERVICE = in_service_q;
  assign NEST_LEVEL = nest_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: priority/mask vector table plus
// hand-written nesting, return and enable-shadow sequences.
module tb_interrupt_controller;

  logic        CLK = 1'b0;
  logic        RESET, COMMIT, EIX, DIX, RETIX;
  logic [3:0]  INT_IN, EDGE_MODE, INT_MASK;
  logic        PC_LD_INT, IEN;
  logic [15:0] INT_VECTOR;
  logic [1:0]  INT_ID;
  logic [3:0]  PENDING, IN_SERVICE;
  logic [1:0]  NEST_LEVEL;

  always #5 CLK = ~CLK;

  interrupt_controller #(
    .NUM_INT   (4),
    .NEST_DEPTH(2),
    .VEC_BASE  (16'h0004),
    .VEC_STRIDE(4)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .COMMIT    (COMMIT),
    .EIX       (EIX),
    .DIX       (DIX),
    .RETIX     (RETIX),
    .INT_IN    (INT_IN),
    .EDGE_MODE (EDGE_MODE),
    .INT_MASK  (INT_MASK),
    .PC_LD_INT (PC_LD_INT),
    .INT_VECTOR(INT_VECTOR),
    .INT_ID    (INT_ID),
    .IEN       (IEN),
    .PENDING   (PENDING),
    .IN_SERVICE(IN_SERVICE),
    .NEST_LEVEL(NEST_LEVEL)
  );

  typedef struct packed {
    logic        ld;
    logic [1:0]  id;
    logic [15:0] vec;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] pulses;
    exp_t       exp;
    logic [3:0] pend_after;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET     = 1'b1;
    INT_IN    = 4'h0;
    INT_MASK  = 4'hF;
    EDGE_MODE = 4'hF;
    tick(2);
    RESET = 1'b0;
  endtask

  // Hold lines high long enough to pass the synchroniser and latch, then drop.
  task automatic pulse(input logic [3:0] lines);
    INT_IN = INT_IN | lines;
    tick(3);
    INT_IN = INT_IN & ~lines;
  endtask

  // One COMMIT cycle: expectation is queued at drive time and popped at sample time.
  task automatic commit_chk(input string name, input logic eix, input logic dix,
                            input logic retix, input logic ld, input logic [1:0] id,
                            input logic [15:0] vec);
    exp_t e;
    sb_q.push_back(exp_t'{ld: ld, id: id, vec: vec});
    COMMIT = 1'b1;
    EIX    = eix;
    DIX    = dix;
    RETIX  = retix;
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got ld=%0b expected an entry", name, PC_LD_INT);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_ld"}, 32'(PC_LD_INT), 32'(e.ld));
      if (e.ld) begin
        chk({name, "_id"}, 32'(INT_ID), 32'(e.id));
        chk({name, "_vec"}, 32'(INT_VECTOR), 32'(e.vec));
      end
    end
    @(posedge CLK);
    #1;
    COMMIT = 1'b0;
    EIX    = 1'b0;
    DIX    = 1'b0;
    RETIX  = 1'b0;
  endtask

  initial begin
    COMMIT = 1'b0;
    EIX    = 1'b0;
    DIX    = 1'b0;
    RETIX  = 1'b0;

    tbl[0] = '{4'b1111, 4'b0100, exp_t'{1'b1, 2'd2, 16'h000C}, 4'b0000};
    tbl[1] = '{4'b1111, 4'b1010, exp_t'{1'b1, 2'd1, 16'h0008}, 4'b1000};
    tbl[2] = '{4'b1111, 4'b1111, exp_t'{1'b1, 2'd0, 16'h0004}, 4'b1110};
    tbl[3] = '{4'b1101, 4'b0010, exp_t'{1'b0, 2'd0, 16'h0000}, 4'b0010};
    tbl[4] = '{4'b0111, 4'b1000, exp_t'{1'b0, 2'd0, 16'h0000}, 4'b1000};
    tbl[5] = '{4'b1000, 4'b1001, exp_t'{1'b1, 2'd3, 16'h0010}, 4'b0001};
    tbl[6] = '{4'b0000, 4'b0000, exp_t'{1'b0, 2'd0, 16'h0000}, 4'b0000};

    // Reset state
    do_reset();
    tick(1);
    chk("rst_pc_ld", 32'(PC_LD_INT), 32'h0);
    chk("rst_vector", 32'(INT_VECTOR), 32'h0004);
    chk("rst_id", 32'(INT_ID), 32'h0);
    chk("rst_ien", 32'(IEN), 32'h0);
    chk("rst_pending", 32'(PENDING), 32'h0);
    chk("rst_in_service", 32'(IN_SERVICE), 32'h0);
    chk("rst_nest", 32'(NEST_LEVEL), 32'h0);

    // Priority / mask table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      INT_MASK = tbl[i].mask;
      commit_chk($sformatf("tbl%0d_ei", i), 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
      pulse(tbl[i].pulses);
      commit_chk($sformatf("tbl%0d_take", i), 1'b0, 1'b0, 1'b0,
                 tbl[i].exp.ld, tbl[i].exp.id, tbl[i].exp.vec);
      chk($sformatf("tbl%0d_pending", i), 32'(PENDING), 32'(tbl[i].pend_after));
    end

    // Basic take of INT2
    do_reset();
    commit_chk("s2_ei", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    INT_IN = 4'b0100;
    tick(2);
    chk("s2_pend_early", 32'(PENDING), 32'h0);
    tick(1);
    chk("s2_pend_3edges", 32'(PENDING), 32'h4);
    INT_IN = 4'b0000;
    commit_chk("s2_take", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h000C);
    chk("s2_ien", 32'(IEN), 32'h0);
    chk("s2_in_service", 32'(IN_SERVICE), 32'h4);
    chk("s2_nest", 32'(NEST_LEVEL), 32'h1);
    chk("s2_pending", 32'(PENDING), 32'h0);

    // Pre-emption and stack limit
    commit_chk("s3_ei0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    pulse(4'b0001);
    commit_chk("s3_take0", 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0004);
    chk("s3_nest2", 32'(NEST_LEVEL), 32'h2);
    chk("s3_is_0101", 32'(IN_SERVICE), 32'h5);
    commit_chk("s3_ei1", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    pulse(4'b0010);
    commit_chk("s3_full", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("s3_still_pend", 32'(PENDING), 32'h2);
    commit_chk("s3_reti", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
    chk("s3_nest_pop", 32'(NEST_LEVEL), 32'h1);
    chk("s3_is_pop", 32'(IN_SERVICE), 32'h4);
    chk("s3_ien_reti", 32'(IEN), 32'h1);
    commit_chk("s3_take1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0008);
    chk("s3_is_0110", 32'(IN_SERVICE), 32'h6);

    // Reset mid-ISR discards nesting
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("s1_mid_nest", 32'(NEST_LEVEL), 32'h0);
    chk("s1_mid_is", 32'(IN_SERVICE), 32'h0);
    chk("s1_mid_ien", 32'(IEN), 32'h0);

    // Simultaneous requests, lower priority blocked while higher in service
    do_reset();
    commit_chk("s4_ei", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    pulse(4'b1010);
    commit_chk("s4_take1", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0008);
    commit_chk("s4_reti", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
    chk("s4_nest0", 32'(NEST_LEVEL), 32'h0);
    commit_chk("s4_take3", 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'h0010);
    commit_chk("s4_reti3", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
    pulse(4'b0010);
    commit_chk("s4_take1b", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0008);
    commit_chk("s4_ei2", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    pulse(4'b1000);
    commit_chk("s4_low_blocked", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("s4_is_0010", 32'(IN_SERVICE), 32'h2);
    chk("s4_pend3", 32'(PENDING), 32'h8);
    commit_chk("s4_reti_dix", 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
    chk("s4_rd_nest", 32'(NEST_LEVEL), 32'h0);
    chk("s4_rd_ien", 32'(IEN), 32'h0);
    chk("s4_rd_is", 32'(IN_SERVICE), 32'h0);
    commit_chk("s4_reti_empty", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
    chk("s4_re_ien", 32'(IEN), 32'h1);
    chk("s4_re_nest", 32'(NEST_LEVEL), 32'h0);

    // Masked edge latches, taken once unmasked
    do_reset();
    commit_chk("s5_ei", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    INT_MASK = 4'b1101;
    pulse(4'b0010);
    commit_chk("s5_masked", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("s5_pend", 32'(PENDING), 32'h2);
    INT_MASK = 4'b1111;
    commit_chk("s5_unmasked", 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'h0008);

    // Level mode, EI/DI precedence, EI shadow
    do_reset();
    EDGE_MODE = 4'b1110;
    INT_IN    = 4'b0001;
    tick(3);
    chk("s6_level_pend", 32'(PENDING), 32'h1);
    INT_IN = 4'b0000;
    tick(3);
    chk("s6_level_drop", 32'(PENDING), 32'h0);
    commit_chk("s6_ei", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    commit_chk("s6_no_take", 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("s6_ien1", 32'(IEN), 32'h1);
    commit_chk("s6_ei_di", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
    chk("s6_ien_di_wins", 32'(IEN), 32'h0);
    pulse(4'b0100);
    commit_chk("s6_shadow", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    commit_chk("s6_take2", 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'h000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised multi-channel interrupt controller. It replaces the fixed two-input (INT0/INT1) interrupt state machine in the core.
- Handles N request lines, each with a per-channel edge or level mode and a per-channel mask.
- Uses fixed priority, with pre-emptive nesting up to a configurable depth.
- Evaluated at the instruction COMMIT phase. Drives the program-counter load strobe and the vector address.

Parameters:
- NUM_INT, 4: number of interrupt request channels (2..16). Channel 0 has the highest priority.
- NEST_DEPTH, 2: maximum number of simultaneously in-service interrupts (1..4).
- VEC_BASE, 16'h0004: vector address of channel 0.
- VEC_STRIDE, 4: address spacing between consecutive channel vectors.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- COMMIT  in  1  instruction commit phase strobe, one cycle per instruction.
- EIX  in  1  enable-interrupts decode, qualified by COMMIT.
- DIX  in  1  disable-interrupts decode, qualified by COMMIT.
- RETIX  in  1  return-from-interrupt decode, qualified by COMMIT.
- INT_IN  in  NUM_INT  raw asynchronous request lines.
- EDGE_MODE  in  NUM_INT  per-channel mode: 1 = rising-edge latched, 0 = level.
- INT_MASK  in  NUM_INT  per-channel enable: 1 = may be taken.
- PC_LD_INT  out  1  combinational; load PC from INT_VECTOR on this clock edge.
- INT_VECTOR  out  16  vector address of the selected channel.
- INT_ID  out  clog2(NUM_INT)  selected channel index.
- IEN  out  1  global interrupt enable.
- PENDING  out  NUM_INT  pending bitmap.
- IN_SERVICE  out  NUM_INT  in-service bitmap.
- NEST_LEVEL  out  clog2(NEST_DEPTH+1)  current stack depth.

Behaviour:
- Reset: every register clears.
  - Synchronisers, edge history, PENDING, IEN, in-service stack, IN_SERVICE and NEST_LEVEL all go to 0.
  - PC_LD_INT = 0, INT_VECTOR = VEC_BASE, INT_ID = 0.
  - Reset mid-ISR discards all nesting state.
- Input path:
  - INT_IN passes through a 2-flop synchroniser, then a previous-value register.
  - The edge on channel i is sync[i] & ~prev[i].
  - prev resets to 0, so a line held high across reset release counts as an edge.
- Pending:
  - Edge channel: the bit sets on an edge and holds until that channel is taken. It is latched even while masked.
  - Level channel: PENDING[i] = sync[i], never latched. If the line drops before it is taken, there is no interrupt.
  - Set and clear on the same edge for the same channel: set wins, so the new edge is kept.
- Candidate selection:
  - cand = PENDING & INT_MASK.
  - sel = lowest set index, produced by a combinational priority encoder.
- Take condition (all must hold in the COMMIT cycle):
  - IEN = 1, using the value registered before this cycle.
  - cand is non-zero.
  - DIX = 0 and RETIX = 0.
  - NEST_LEVEL < NEST_DEPTH.
  - NEST_LEVEL = 0, or sel < top-of-stack id (strictly higher priority).
- When taken:
  - In that same cycle: PC_LD_INT = 1, INT_ID = sel, INT_VECTOR = VEC_BASE + sel*VEC_STRIDE (16-bit, wraps modulo 2^16).
  - On that edge: push sel onto the stack, NEST_LEVEL +1, IN_SERVICE[sel] = 1, IEN = 0, and clear PENDING[sel] if the channel is edge mode.
- When not taken: PC_LD_INT = 0. INT_VECTOR and INT_ID still show the current candidate, but are don't-care.
- EIX at COMMIT:
  - IEN = 1 from the next cycle.
  - The take check in the same COMMIT uses the old IEN, giving a one-instruction shadow.
- DIX at COMMIT:
  - IEN = 0, and suppresses any take in that cycle.
  - EIX and DIX together: DIX wins.
- RETIX at COMMIT:
  - Pop the top of stack, clear its IN_SERVICE bit, NEST_LEVEL -1, IEN = 1.
  - No take in the same cycle; the next COMMIT may take.
  - RETIX with an empty stack: IEN = 1 only, stack unchanged, no underflow.
  - RETIX together with DIX: the pop still happens and DIX wins for IEN, so IEN = 0.
- COMMIT low: EIX, DIX and RETIX are ignored, no take, only the pending/synchroniser logic advances.
- Stack full (NEST_LEVEL = NEST_DEPTH): no take of any priority. Requests stay pending.

Decomposition:
- Shared constants file: default VEC_BASE and VEC_STRIDE, the clog2 width function, and the EDGE/LEVEL mode encodings.
- One sub-module, int_priority_encoder: parametrised, combinational, outputs lowest set index plus a valid flag.
- Stack, synchronisers and IEN logic stay in the top module.

Test Plan:
All scenarios use NUM_INT=4, NEST_DEPTH=2, VEC_BASE=0x0004, VEC_STRIDE=4, INT_MASK=4'b1111, EDGE_MODE=4'b1111 unless noted.
1. Reset with INT_IN=0 -> all outputs 0, INT_VECTOR=0x0004. Assert RESET mid-ISR at NEST_LEVEL=1 -> NEST_LEVEL=0, IN_SERVICE=0, IEN=0 on the next edge.
2. EI at COMMIT, then raise INT_IN[2] -> PENDING[2]=1 three clock edges later.
   - Next COMMIT: PC_LD_INT=1, INT_ID=2, INT_VECTOR=0x000C.
   - After that edge: IEN=0, IN_SERVICE=4'b0100, NEST_LEVEL=1, PENDING[2]=0.
3. Pre-emption and stack limit, continuing from scenario 2:
   - Issue EI, then raise INT0 -> taken, vector 0x0004, NEST_LEVEL=2, IN_SERVICE=4'b0101.
   - Issue EI, then raise INT1 -> PC_LD_INT stays 0 (stack full).
   - RETI -> NEST_LEVEL=1. Next COMMIT takes INT1 (vector 0x0008), because 1 < 2.
4. INT1 and INT3 pending together, IEN=1 -> INT1 taken first (0x0008).
   - RETI, next COMMIT -> INT3 taken (0x0010).
   - While IN_SERVICE=4'b0010 with IEN=1, a new INT3 is not taken (lower priority).
5. INT_MASK[1]=0 and INT_IN[1] pulses -> PENDING[1] latches, no take. Set INT_MASK[1]=1 -> taken at the next COMMIT.
6. EDGE_MODE[0]=0 (level): raise INT_IN[0] while IEN=0, drop it, then EI -> no take.
   - At one COMMIT with EIX=DIX=1 -> IEN=0.
   - EIX alone with INT2 pending -> no take in that COMMIT; taken at the next COMMIT.
